operate_tx_scheduler: RTL and testbench
=======================================

// Module: operate_tx_scheduler
// PURPOSE
//  Downstream of the operate verifier: buffers verified operate bytes and paces them onto the UART TX.
//  Drops OPERATE_IGNORE bytes and queues real commands in a small FIFO.
//  Sends one byte per TX handshake and enforces a minimum inter-command gap so the game client never overruns.
// PARAMETERS
//  FIFO_DEPTH   4             queue entries; power of 2, >=2
//  GAP_CYCLES   16'd1000      min idle cycles between end of one TX and next tx_start; 0 = no gap
//  IGNORE_BYTE  8'b1_00000_10 operate code that is never queued
// PORTS
//  uart_clk      in   1  sole clock
//  rst           in   1  asynchronous reset, active-high
//  op_in         in   8  verified operate byte
//  op_valid      in   1  1-cycle strobe; op_in is valid this cycle
//  flush         in   1  sync clear of queue (game stopped); takes priority over push
//  tx_ready      in   1  UART TX idle/can accept
//  tx_data       out  8  byte presented to UART TX
//  tx_start      out  1  1-cycle send strobe
//  fifo_full     out  1  queue holds FIFO_DEPTH entries
//  fifo_empty    out  1  queue holds 0 entries
//  drop_count    out  8  saturating count of bytes lost to full queue
// BEHAVIOUR
//  Reset (async): FIFO empty, FSM=IDLE, tx_data=IGNORE_BYTE, tx_start=0, fifo_full=0, fifo_empty=1, drop_count=0, gap counter=0.
//  Push: op_valid & op_in!=IGNORE_BYTE & !flush. Accepted if not full, or if full and a pop happens in the same cycle.
//  Refused pushes increment drop_count; it saturates at 8'hFF. IGNORE_BYTE never counts as a drop.
//  Pop happens in IDLE when !fifo_empty & tx_ready. The head byte is registered into tx_data and the FSM goes to SEND.
//  FSM states: IDLE -> SEND -> BUSY -> GAP -> IDLE.
//   SEND: tx_start=1 for exactly 1 cycle, then BUSY. tx_data is held stable from SEND until the next pop.
//   BUSY: the cycle after SEND is ignored (TX drops ready there); afterwards wait for tx_ready=1, then GAP.
//   GAP: counter loads GAP_CYCLES-1 and counts down; at 0 -> IDLE. With GAP_CYCLES=0, BUSY goes straight to IDLE.
//  Latency: push into an empty queue with tx_ready=1 and FSM in IDLE -> tx_start asserted 2 cycles later.
//  flush: empties the queue next cycle and does not affect drop_count.
//   Flush in SEND/BUSY lets the current byte complete and the gap run.
//   Flush in GAP aborts the gap -> IDLE.
//  Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap naturally; occupancy counter is log2(FIFO_DEPTH)+1 bits.
//  Order is strictly FIFO; no reordering, no retransmit.
// CONFIGURATION
//  OPERATE_TX_DEDUP_EN defined:
//   A push whose op_in equals the most recently accepted byte, while the queue is non-empty, is discarded silently.
//   Discarded means: not queued, and drop_count is unchanged.
//   The last-accepted register resets to IGNORE_BYTE and is cleared by flush.
//  Undefined: every non-IGNORE push is queued and duplicates are kept.
// STRUCTURE
//  Shared package/header operate_defs: OPERATE_GET/PUT/INTERACT/MOVE/THROW/IGNORE codes and FSM state encodings.
//   The verifier uses the same constants.
//  Sub-module op_sync_fifo (DEPTH, WIDTH=8): push/pop/flush/full/empty plus simultaneous push+pop when full.
//  Top holds the FSM, gap counter, drop counter and dedup register.
// TESTING
//  1 Reset, push MOVE 8'b1_01000_10 with tx_ready=1 -> tx_start pulses 2 cycles later, tx_data=8'hA2, exactly 1 cycle.
//  2 Push IGNORE 8'h82 x3 -> fifo_empty stays 1, no tx_start, drop_count=0.
//  3 Hold tx_ready=0, push 6 distinct ops with DEPTH=4 -> fifo_full=1, drop_count=2; release -> 4 bytes sent in push order.
//  4 GAP_CYCLES=10, queue 2 ops -> >=10 cycles between tx_ready returning high and the second tx_start.
//  5 Assert rst mid-BUSY with 3 queued -> outputs at reset values immediately; no tx_start after release.
//  6 DEDUP_EN: push GET,GET,PUT with tx_ready=0 -> 2 entries queued, drop_count=0; undefined -> 3 entries.

Source files
------------

// File: rtl/operate_defs.sv
// Operate command codes and scheduler FSM encodings.
// The operate verifier uses the same constants.
package operate_defs;

  localparam logic [7:0] OPERATE_GET      = 8'b1_00001_10;
  localparam logic [7:0] OPERATE_PUT      = 8'b1_00010_10;
  localparam logic [7:0] OPERATE_INTERACT = 8'b1_00100_10;
  localparam logic [7:0] OPERATE_MOVE     = 8'b1_01000_10;
  localparam logic [7:0] OPERATE_THROW    = 8'b1_10000_10;
  localparam logic [7:0] OPERATE_IGNORE   = 8'b1_00000_10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/op_sync_fifo.sv
// Small synchronous FIFO with flush; a push into a full queue is accepted
// when a pop happens in the same cycle.
module op_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);
  assign rd_en = pop && !empty && !flush;
  assign wr_en = push && (!full || rd_en) && !flush;
  assign dout  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/operate_tx_scheduler.sv
// Queues verified operate bytes and paces them onto the UART TX with a minimum gap.
// Optional OPERATE_TX_DEDUP_EN discards repeats of the last accepted byte while queued.
module operate_tx_scheduler
  import operate_defs::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] GAP_CYCLES  = 16'd1000,
  parameter logic [7:0]  IGNORE_BYTE = 8'b1_00000_10
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic [7:0] op_in,
  input  logic       op_valid,
  input  logic       flush,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic [7:0] drop_count
);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic        busy_skip_reg;
  logic [15:0] gap_cnt_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_start_reg;
  logic [7:0]  drop_reg;
  logic [7:0]  head_byte;
  logic        pop;
  logic        push_req;
  logic        dup_hit;
  logic        push_ok;
  logic        push_drop;

  assign pop      = (state_reg == ST_IDLE) && !fifo_empty && tx_ready && !flush;
  assign push_req = op_valid && (op_in != IGNORE_BYTE) && !flush;

`ifdef OPERATE_TX_DEDUP_EN
  logic [7:0] last_reg;

  assign dup_hit = push_req && !fifo_empty && (op_in == last_reg);

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst)          last_reg <= IGNORE_BYTE;
    else if (flush)   last_reg <= IGNORE_BYTE;
    else if (push_ok) last_reg <= op_in;
  end
`else
  assign dup_hit = 1'b0;
`endif

  // A duplicate is discarded silently and never counts as a drop.
  assign push_ok   = push_req && !dup_hit && (!fifo_full || pop);
  assign push_drop = push_req && !dup_hit && fifo_full && !pop;

  op_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (uart_clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .flush (flush),
    .din   (op_in),
    .dout  (head_byte),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // BUSY ignores tx_ready on its first cycle while the UART is still dropping ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (pop) state_next = ST_SEND;
      ST_SEND: state_next = ST_BUSY;
      ST_BUSY: begin
        if (!busy_skip_reg && tx_ready)
          state_next = (GAP_CYCLES == 16'd0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP:  if (flush || gap_cnt_reg == 16'd0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      busy_skip_reg <= 1'b0;
      gap_cnt_reg   <= 16'd0;
      tx_data_reg   <= IGNORE_BYTE;
      tx_start_reg  <= 1'b0;
      drop_reg      <= 8'd0;
    end else begin
      state_reg     <= state_next;
      busy_skip_reg <= (state_reg == ST_SEND);
      tx_start_reg  <= pop;
      if (pop) tx_data_reg <= head_byte;
      if (state_reg == ST_BUSY && state_next == ST_GAP)
        gap_cnt_reg <= GAP_CYCLES - 16'd1;
      else if (state_reg == ST_GAP && gap_cnt_reg != 16'd0)
        gap_cnt_reg <= gap_cnt_reg - 16'd1;
      if (push_drop && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
    end
  end

  assign tx_data    = tx_data_reg;
  assign tx_start   = tx_start_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_operate_tx_scheduler.sv
// Directed bench for operate_tx_scheduler with a queue/timestamp reference model
// checked every cycle; follows OPERATE_TX_DEDUP_EN when it is defined.
module tb_operate_tx_scheduler;
  import operate_defs::*;

  localparam int          DEPTH = 4;
  localparam int          GAP   = 10;
  localparam logic [7:0]  IGN   = 8'h82;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] op_in = 8'h00;
  logic       op_valid = 1'b0;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  operate_tx_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .GAP_CYCLES  (16'(GAP)),
    .IGNORE_BYTE (IGN)
  ) dut (
    .uart_clk   (clk),
    .rst        (rst),
    .op_in      (op_in),
    .op_valid   (op_valid),
    .flush      (flush),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus edge timestamps for when the link may pop again.
  logic [7:0] mq[$];
  int         m_drop;
  logic [7:0] m_last;
  logic [7:0] m_tx_data;
  logic       m_tx_start;
  bit         m_wait;
  int         m_pop_e, m_done_e, m_next_e;
  int         e = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_drop = 0; m_last = IGN; m_tx_data = IGN; m_tx_start = 1'b0;
      m_wait = 0; m_pop_e = 0; m_done_e = -100; m_next_e = 0;
    end else begin
      bit req, disc, pop, acc;
      e = e + 1;
      pop  = !m_wait && (e >= m_next_e) && (mq.size() > 0) && tx_ready && !flush;
      req  = op_valid && (op_in != IGN) && !flush;
      disc = 0;
`ifdef OPERATE_TX_DEDUP_EN
      disc = req && (mq.size() > 0) && (op_in == m_last);
`endif
      acc = req && !disc && ((mq.size() < DEPTH) || pop);
      if (req && !disc && !acc && m_drop < 255) m_drop++;
      if (m_wait && e >= m_pop_e + 3 && tx_ready) begin
        m_wait = 0; m_done_e = e; m_next_e = e + GAP + 1;
      end else if (!m_wait && flush && e > m_done_e && e < m_next_e) begin
        m_next_e = e + 1;
      end
      m_tx_start = pop;
      if (pop) begin
        m_tx_data = mq.pop_front();
        m_wait = 1; m_pop_e = e;
      end
      if (flush) begin
        mq.delete(); m_last = IGN;
      end else if (acc) begin
        mq.push_back(op_in); m_last = op_in;
      end
    end
  end

  logic [7:0] tx_bytes[$];
  int         tx_cycles[$];
  int         n_tx = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("tx_start",   32'(tx_start),   32'(m_tx_start));
      check("tx_data",    32'(tx_data),    32'(m_tx_data));
      check("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
      check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (tx_start) begin
        tx_bytes.push_back(tx_data);
        tx_cycles.push_back(e);
        n_tx++;
        $display("tx  byte=%02h cycle=%0d drops=%0d", tx_data, e, drop_count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [7:0] b);
    op_valid = 1'b1; op_in = b;
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_tx < target; i++) step();
    check(name, 32'(n_tx), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pc, rc, exp_n;
    logic [7:0] exp3 [4];
    logic [7:0] b;

    // Reset values
    step(); step();
    check("rst_tx_data", 32'(tx_data), 32'h82);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_empty", 32'(fifo_empty), 32'h1);
    check("rst_full", 32'(fifo_full), 32'h0);
    check("rst_drop", 32'(drop_count), 32'h0);
    rst = 1'b0;
    step();

    // 1: single MOVE, two-cycle latency
    tx_ready = 1'b1;
    pc = e;
    push_op(OPERATE_MOVE);
    wait_tx(1, 20, "t1_tx_seen");
    check("t1_byte", 32'(tx_bytes[0]), 32'hA2);
    check("t1_latency", 32'(tx_cycles[0] - pc), 32'd2);
    for (int i = 0; i < 20; i++) step();
    check("t1_single_pulse", 32'(n_tx), 32'd1);

    // 2: IGNORE bytes never queue or drop
    for (int i = 0; i < 3; i++) push_op(8'h82);
    step(); step();
    check("t2_empty", 32'(fifo_empty), 32'h1);
    check("t2_drop", 32'(drop_count), 32'h0);
    check("t2_no_tx", 32'(n_tx), 32'd1);

    // 3: overflow with TX stalled, then drain in order
    tx_ready = 1'b0;
    push_op(OPERATE_GET); push_op(OPERATE_PUT); push_op(OPERATE_INTERACT);
    push_op(OPERATE_MOVE); push_op(OPERATE_THROW); push_op(8'h55);
    check("t3_full", 32'(fifo_full), 32'h1);
    check("t3_drop", 32'(drop_count), 32'd2);
    exp3[0] = 8'h86; exp3[1] = 8'h8A; exp3[2] = 8'h92; exp3[3] = 8'hA2;
    base = n_tx;
    tx_ready = 1'b1;
    wait_tx(base + 4, 200, "t3_drain");
    for (int i = 0; i < 4; i++)
      if (base + i < n_tx) check("t3_order", 32'(tx_bytes[base + i]), 32'(exp3[i]));
    for (int i = 0; i < 20; i++) step();

    // 4: gap between tx_ready returning and the next start
    tx_ready = 1'b0;
    push_op(OPERATE_GET); push_op(OPERATE_PUT);
    base = n_tx;
    tx_ready = 1'b1;
    wait_tx(base + 1, 20, "t4_first");
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tx_ready = 1'b1;
    rc = e;
    wait_tx(base + 2, 60, "t4_second");
    if (n_tx >= base + 2) check("t4_gap", 32'(tx_cycles[base + 1] - rc), 32'd12);
    for (int i = 0; i < 20; i++) step();

    // 5: async reset mid-BUSY with three bytes queued
    tx_ready = 1'b0;
    push_op(OPERATE_GET); push_op(OPERATE_PUT); push_op(OPERATE_MOVE); push_op(OPERATE_THROW);
    push_op(OPERATE_INTERACT);
    base = n_tx;
    tx_ready = 1'b1;
    wait_tx(base + 1, 20, "t5_first");
    tx_ready = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("t5_tx_data", 32'(tx_data), 32'h82);
    check("t5_tx_start", 32'(tx_start), 32'h0);
    check("t5_empty", 32'(fifo_empty), 32'h1);
    check("t5_full", 32'(fifo_full), 32'h0);
    check("t5_drop", 32'(drop_count), 32'h0);
    step(); step();
    rst = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("t5_no_tx", 32'(n_tx), 32'(base + 1));

    // 6: duplicate handling
    tx_ready = 1'b0;
    push_op(OPERATE_GET); push_op(OPERATE_GET); push_op(OPERATE_PUT);
    check("t6_drop", 32'(drop_count), 32'h0);
`ifdef OPERATE_TX_DEDUP_EN
    exp_n = 2;
`else
    exp_n = 3;
`endif
    base = n_tx;
    tx_ready = 1'b1;
    wait_tx(base + exp_n, 200, "t6_drain");
    for (int i = 0; i < 30; i++) step();
    check("t6_count", 32'(n_tx), 32'(base + exp_n));
    if (n_tx >= base + exp_n)
      check("t6_last", 32'(tx_bytes[base + exp_n - 1]), 32'h8A);

    // 7: flush of a stalled queue, then flush during the gap
    tx_ready = 1'b0;
    push_op(OPERATE_INTERACT); push_op(OPERATE_THROW);
    flush = 1'b1; step(); flush = 1'b0;
    check("t7_empty", 32'(fifo_empty), 32'h1);
    check("t7_drop", 32'(drop_count), 32'h0);
    base = n_tx;
    tx_ready = 1'b1;
    push_op(OPERATE_MOVE);
    wait_tx(base + 1, 20, "t7_first");
    push_op(OPERATE_GET);
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    push_op(OPERATE_PUT);
    wait_tx(base + 2, 20, "t7_after_flush");
    if (n_tx >= base + 2) check("t7_byte", 32'(tx_bytes[base + 1]), 32'h8A);
    for (int i = 0; i < 20; i++) step();

    // 8: drop counter saturates and survives flush
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b = 8'(i);
      if (b == IGN) b = 8'h11;
      push_op(b);
    end
    check("t8_sat", 32'(drop_count), 32'hFF);
    flush = 1'b1; step(); flush = 1'b0;
    check("t8_flush_keep", 32'(drop_count), 32'hFF);
    check("t8_flush_empty", 32'(fifo_empty), 32'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
